// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants and helpers for the round-robin arbiter and its ingress
// queue front end.
//   N_CH_DEFAULT   number of requesters (arbiter width)
//   DW_DEFAULT     data word width
//   DEPTH_DEFAULT  entries per channel FIFO
//   CH_W           channel index width, clog2(N_CH_DEFAULT)
//   onehot_to_idx  one-hot grant vector to binary channel index
// -----------------------------------------------------------------------------
package arb_pkg;

   localparam int N_CH_DEFAULT  = 4;
   localparam int DW_DEFAULT    = 8;
   localparam int DEPTH_DEFAULT = 4;
   localparam int CH_W          = $clog2(N_CH_DEFAULT);

   // OR of the indices of all set bits; exact for a one-hot input, 0 for idle
   function automatic logic [CH_W-1:0] onehot_to_idx(input logic [N_CH_DEFAULT-1:0] oh);
      logic [CH_W-1:0] idx;
      idx = {CH_W{1'b0}};
      for (int i = 0; i < N_CH_DEFAULT; i++) begin
         if (oh[i]) begin
            idx = idx | CH_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/req_queue_frontend_if.sv
// -----------------------------------------------------------------------------
// req_queue_frontend_if
// Bundles the ingress write channels, the arbiter req/gnt pair and the single
// output channel of req_queue_frontend.
//   in_valid/in_data/in_ready  per-channel write handshake (in_data lane i is
//                              [i*DW +: DW])
//   req/gnt                    request vector to, one-hot grant from arbiter
//   out_valid/out_data/out_ch  popped word and its source channel
//   gnt_err                    sticky grant protocol error
// Modports: master = sources/arbiter side, slave = the queue front end.
// -----------------------------------------------------------------------------
interface req_queue_frontend_if #(
   parameter int N_CH = arb_pkg::N_CH_DEFAULT,
   parameter int DW   = arb_pkg::DW_DEFAULT
);

   logic [N_CH-1:0]          in_valid;
   logic [N_CH*DW-1:0]       in_data;
   logic [N_CH-1:0]          in_ready;
   logic [N_CH-1:0]          req;
   logic [N_CH-1:0]          gnt;
   logic                     out_valid;
   logic [DW-1:0]            out_data;
   logic [$clog2(N_CH)-1:0]  out_ch;
   logic                     gnt_err;

   modport master (
      output in_valid, in_data, gnt,
      input  in_ready, req, out_valid, out_data, out_ch, gnt_err
   );

   modport slave (
      input  in_valid, in_data, gnt,
      output in_ready, req, out_valid, out_data, out_ch, gnt_err
   );

endinterface

// File: rtl/req_fifo.sv
// -----------------------------------------------------------------------------
// req_fifo
// Synchronous show-ahead FIFO for one requester channel.
//   clk    rising-edge clock
//   rst    synchronous active-high reset (pointers and count to 0)
//   push   write din (ignored while full)
//   pop    drop the head entry (ignored while empty)
//   din    write data
//   dout   current head entry (valid while !empty)
//   count  number of stored entries, 0..DEPTH
//   full   count == DEPTH
//   empty  count == 0
// full/empty come from the registered count only, so a pop in the same cycle
// never makes room for a push.
// -----------------------------------------------------------------------------
module req_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (count_r == (AW+1)'(DEPTH));
   assign empty     = (count_r == {(AW+1){1'b0}});
   assign count     = count_r;
   assign dout      = mem_r[rd_ptr_r];
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;

   // Storage array; contents are don't-care while empty so it carries no reset
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1'b1);
            2'b01:   count_r <= count_r - (AW+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/req_queue_frontend.sv
// -----------------------------------------------------------------------------
// req_queue_frontend
// Per-requester ingress queueing in front of the N_CH-way round-robin arbiter.
// Each source writes into its own req_fifo; req[i] flags a non-empty FIFO.
// A grant pops the granted FIFO and the head word appears one cycle later on
// the registered output channel.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   req_queue_frontend_if.slave (in_*, req, gnt, out_*, gnt_err)
// Optional build macro GNT_CHECK_EN adds a sticky grant protocol checker on
// gnt_err; without it gnt_err is tied 0. The datapath is the same either way.
// -----------------------------------------------------------------------------
module req_queue_frontend
   import arb_pkg::*;
#(
   parameter int N_CH  = N_CH_DEFAULT,
   parameter int DW    = DW_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   req_queue_frontend_if.slave   bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [N_CH-1:0] LSB_ONE = {{(N_CH-1){1'b0}}, 1'b1};

   logic [DW-1:0]   head_s  [N_CH];
   logic [CW-1:0]   count_s [N_CH];
   logic [N_CH-1:0] full_s;
   logic [N_CH-1:0] empty_s;
   logic [N_CH-1:0] pop_sel_s;
   logic [N_CH-1:0] pop_oh_s;
   logic [CH_W-1:0] pop_idx_s;
   logic            pop_any_s;

   logic            out_valid_r;
   logic [DW-1:0]   out_data_r;
   logic [CH_W-1:0] out_ch_r;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      req_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (bus.in_valid[i]),
         .pop   (pop_oh_s[i]),
         .din   (bus.in_data[i*DW +: DW]),
         .dout  (head_s[i]),
         .count (count_s[i]),
         .full  (full_s[i]),
         .empty (empty_s[i])
      );

      assign bus.req[i] = (count_s[i] != {CW{1'b0}});
   end

   assign bus.in_ready = ~full_s;

   // Grant decode: stale grants on empty FIFOs are masked out, and of the
   // remaining bits only the lowest one pops (x & -x isolates it)
   always_comb begin
      pop_sel_s = bus.gnt & ~empty_s;
      pop_oh_s  = pop_sel_s & (~pop_sel_s + LSB_ONE);
      pop_idx_s = onehot_to_idx(pop_oh_s);
      pop_any_s = |pop_sel_s;
   end

   // Output register: valid pulses for one cycle per pop, data/channel hold
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {DW{1'b0}};
         out_ch_r    <= {CH_W{1'b0}};
      end else begin
         out_valid_r <= pop_any_s;
         if (pop_any_s) begin
            out_data_r <= head_s[pop_idx_s];
            out_ch_r   <= pop_idx_s;
         end else begin
            out_data_r <= out_data_r;
            out_ch_r   <= out_ch_r;
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_ch    = out_ch_r;

`ifdef GNT_CHECK_EN
   logic [N_CH-1:0] stale_s;
   logic [N_CH-1:0] stale_r;
   logic            multi_s;
   logic            gnt_err_r;

   // A grant on an empty FIFO is the registered arbiter lagging by one pop;
   // only a repeat on the same channel next cycle is a protocol violation
   always_comb begin
      stale_s = bus.gnt & empty_s;
      multi_s = ((bus.gnt & (bus.gnt - LSB_ONE)) != {N_CH{1'b0}});
   end

   // Sticky error flag plus last-cycle stale history
   always_ff @(posedge clk) begin
      if (rst) begin
         stale_r   <= {N_CH{1'b0}};
         gnt_err_r <= 1'b0;
      end else begin
         stale_r   <= stale_s;
         gnt_err_r <= gnt_err_r | multi_s | (|(stale_s & stale_r));
      end
   end

   assign bus.gnt_err = gnt_err_r;
`else
   assign bus.gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_req_queue_frontend.sv
module tb_req_queue_frontend;
   import arb_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   req_queue_frontend_if #(.N_CH(4), .DW(8)) bus_if ();

   req_queue_frontend #(
      .N_CH  (4),
      .DW    (8),
      .DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] w;
      logic [3:0] g;
      logic [1:0] last;
      logic [1:0] idx;
      logic       found;
      logic       exp_err;
      int         ch;

      checks = 0;
      errors = 0;
`ifdef GNT_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif

      // 1. reset held two cycles with writes requested
      rst              = 1'b1;
      bus_if.in_valid  = 4'b1111;
      bus_if.in_data   = 32'h0000_0000;
      bus_if.gnt       = 4'b0000;
      step();
      chk("rst_in_ready", 32'(bus_if.in_ready), 32'h0000_000F);
      chk("rst_req", 32'(bus_if.req), 32'h0);
      chk("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
      chk("rst_out_data", 32'(bus_if.out_data), 32'h0);
      chk("rst_out_ch", 32'(bus_if.out_ch), 32'h0);
      chk("rst_gnt_err", 32'(bus_if.gnt_err), 32'h0);
      step();
      chk("rst2_in_ready", 32'(bus_if.in_ready), 32'h0000_000F);
      chk("rst2_req", 32'(bus_if.req), 32'h0);
      chk("rst2_out_valid", 32'(bus_if.out_valid), 32'h0);
      rst             = 1'b0;
      bus_if.in_valid = 4'b0000;

      // 2. single push on ch2, single grant
      bus_if.in_valid = 4'b0100;
      bus_if.in_data  = 32'h00A5_0000;
      step();
      bus_if.in_valid = 4'b0000;
      chk("single_req", 32'(bus_if.req), 32'h4);
      bus_if.gnt = 4'b0100;
      step();
      bus_if.gnt = 4'b0000;
      chk("single_valid", 32'(bus_if.out_valid), 32'h1);
      chk("single_data", 32'(bus_if.out_data), 32'hA5);
      chk("single_ch", 32'(bus_if.out_ch), 32'h2);
      chk("single_req_fall", 32'(bus_if.req), 32'h0);
      step();
      chk("single_valid_fall", 32'(bus_if.out_valid), 32'h0);
      chk("single_data_hold", 32'(bus_if.out_data), 32'hA5);

      // 3. fill ch0, overflow dropped, then drain in order
      for (int k = 0; k < 4; k++) begin
         w = 8'hC0 + 8'(k);
         bus_if.in_valid = 4'b0001;
         bus_if.in_data  = {24'h000000, w};
         step();
      end
      chk("fill_in_ready", 32'(bus_if.in_ready), 32'hE);
      bus_if.in_data = 32'h0000_00C4;
      step();
      chk("fill_drop_in_ready", 32'(bus_if.in_ready), 32'hE);
      chk("fill_req", 32'(bus_if.req), 32'h1);
      // full FIFO granted while a write is offered: pop only
      bus_if.in_data = 32'h0000_00EE;
      bus_if.gnt     = 4'b0001;
      step();
      bus_if.in_valid = 4'b0000;
      chk("fill_pop0_valid", 32'(bus_if.out_valid), 32'h1);
      chk("fill_pop0_data", 32'(bus_if.out_data), 32'hC0);
      chk("fill_pop0_ch", 32'(bus_if.out_ch), 32'h0);
      chk("fill_pop0_ready", 32'(bus_if.in_ready), 32'hF);
      for (int k = 1; k < 4; k++) begin
         step();
         w = 8'hC0 + 8'(k);
         chk("fill_pop_valid", 32'(bus_if.out_valid), 32'h1);
         chk("fill_pop_data", 32'(bus_if.out_data), 32'(w));
      end
      chk("fill_req_fall", 32'(bus_if.req), 32'h0);
      bus_if.gnt = 4'b0000;
      step();
      chk("fill_idle_valid", 32'(bus_if.out_valid), 32'h0);

      // 4. wrap-around with concurrent push/pop on ch1 at count 2
      for (int k = 0; k < 2; k++) begin
         w = 8'h10 + 8'(k);
         bus_if.in_valid = 4'b0010;
         bus_if.in_data  = {16'h0000, w, 8'h00};
         step();
      end
      for (int k = 0; k < 10; k++) begin
         w = 8'h12 + 8'(k);
         bus_if.in_valid = 4'b0010;
         bus_if.in_data  = {16'h0000, w, 8'h00};
         bus_if.gnt      = 4'b0010;
         step();
         w = 8'h10 + 8'(k);
         chk("wrap_valid", 32'(bus_if.out_valid), 32'h1);
         chk("wrap_data", 32'(bus_if.out_data), 32'(w));
         chk("wrap_ready", 32'(bus_if.in_ready), 32'hF);
         chk("wrap_req", 32'(bus_if.req), 32'h2);
      end
      bus_if.in_valid = 4'b0000;
      step();
      chk("wrap_tail0", 32'(bus_if.out_data), 32'h1A);
      step();
      chk("wrap_tail1", 32'(bus_if.out_data), 32'h1B);
      chk("wrap_tail_ch", 32'(bus_if.out_ch), 32'h1);
      chk("wrap_req_fall", 32'(bus_if.req), 32'h0);
      bus_if.gnt = 4'b0000;
      step();
      chk("wrap_idle_valid", 32'(bus_if.out_valid), 32'h0);

      // 5. stale grant on ch3
      bus_if.in_valid = 4'b1000;
      bus_if.in_data  = 32'h3C00_0000;
      step();
      bus_if.in_valid = 4'b0000;
      bus_if.gnt      = 4'b1000;
      step();
      chk("stale_pop_valid", 32'(bus_if.out_valid), 32'h1);
      chk("stale_pop_data", 32'(bus_if.out_data), 32'h3C);
      chk("stale_pop_ch", 32'(bus_if.out_ch), 32'h3);
      step();
      chk("stale1_valid", 32'(bus_if.out_valid), 32'h0);
      chk("stale1_gnt_err", 32'(bus_if.gnt_err), 32'h0);
      step();
      chk("stale2_valid", 32'(bus_if.out_valid), 32'h0);
      chk("stale2_gnt_err", 32'(bus_if.gnt_err), 32'(exp_err));
      bus_if.gnt = 4'b0000;

      // non-one-hot grant: lowest non-empty granted channel wins
      bus_if.in_valid = 4'b0110;
      bus_if.in_data  = 32'h0052_5100;
      step();
      bus_if.in_valid = 4'b0000;
      bus_if.gnt      = 4'b0111;
      step();
      bus_if.gnt = 4'b0000;
      chk("multi_valid", 32'(bus_if.out_valid), 32'h1);
      chk("multi_ch", 32'(bus_if.out_ch), 32'h1);
      chk("multi_data", 32'(bus_if.out_data), 32'h51);
      chk("multi_req", 32'(bus_if.req), 32'h4);
      bus_if.gnt = 4'b0100;
      step();
      bus_if.gnt = 4'b0000;
      chk("multi_drain_data", 32'(bus_if.out_data), 32'h52);
      chk("multi_drain_req", 32'(bus_if.req), 32'h0);

      // 6. round-robin arbiter driving all four preloaded FIFOs
      for (int k = 0; k < 3; k++) begin
         bus_if.in_valid = 4'b1111;
         bus_if.in_data  = {8'h30 + 8'(k), 8'h20 + 8'(k), 8'h10 + 8'(k), 8'h00 + 8'(k)};
         step();
      end
      bus_if.in_valid = 4'b0000;
      chk("rr_preload_req", 32'(bus_if.req), 32'hF);
      chk("rr_preload_ready", 32'(bus_if.in_ready), 32'hF);
      last = 2'd3;
      for (int n = 0; n < 12; n++) begin
         g     = 4'b0000;
         found = 1'b0;
         for (int off = 1; off <= 4; off++) begin
            idx = last + 2'(off);
            if (!found && bus_if.req[idx]) begin
               g[idx] = 1'b1;
               found  = 1'b1;
            end
         end
         bus_if.gnt = g;
         step();
         last = onehot_to_idx(g);
         ch   = n % 4;
         w    = 8'(16 * ch + n / 4);
         chk("rr_valid", 32'(bus_if.out_valid), 32'h1);
         chk("rr_ch", 32'(bus_if.out_ch), 32'(ch));
         chk("rr_data", 32'(bus_if.out_data), 32'(w));
      end
      bus_if.gnt = 4'b0000;
      chk("rr_req_empty", 32'(bus_if.req), 32'h0);
      step();
      chk("rr_idle_valid", 32'(bus_if.out_valid), 32'h0);

      // reset mid-operation discards queued data and the pending pop
      bus_if.in_valid = 4'b0001;
      bus_if.in_data  = 32'h0000_0077;
      step();
      bus_if.in_valid = 4'b0000;
      bus_if.gnt      = 4'b0001;
      rst             = 1'b1;
      step();
      rst        = 1'b0;
      bus_if.gnt = 4'b0000;
      chk("midrst_valid", 32'(bus_if.out_valid), 32'h0);
      chk("midrst_data", 32'(bus_if.out_data), 32'h0);
      chk("midrst_req", 32'(bus_if.req), 32'h0);
      chk("midrst_gnt_err", 32'(bus_if.gnt_err), 32'h0);
      step();
      chk("midrst_no_pulse", 32'(bus_if.out_valid), 32'h0);
      chk("midrst_ready", 32'(bus_if.in_ready), 32'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
